// File: rtl/wash_sequencer.sv
// Washing machine program sequencer: walks the machine through power-up,
// program selection, running, pausing, door-open alarm and end-of-cycle
// alarm, and builds the packed stage-duration word for the run controller.
module wash_sequencer #(
    parameter logic [2:0]  INIT_SEC   = 3'd5,
    parameter logic [2:0]  FINISH_SEC = 3'd5,
    parameter logic [25:0] BASE_PROG  = 26'h1AB490B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        power_btn,
    input  logic        start_btn,
    input  logic        mode_btn,
    input  logic        door_open,
    input  logic        run_done,
    output logic [2:0]  state,
    output logic [25:0] data,
    output logic [2:0]  mode,
    output logic [2:0]  sec_left,
    output logic        buzzer
);

    typedef enum logic [2:0] {
        S_SHUTDOWN = 3'd0,
        S_BEGIN    = 3'd1,
        S_SET      = 3'd2,
        S_RUN      = 3'd3,
        S_ERROR    = 3'd4,
        S_PAUSE    = 3'd5,
        S_FINISH   = 3'd6
    } state_t;

    state_t      state_q;
    state_t      err_ret_q;
    logic [2:0]  mode_q;
    logic [2:0]  sec_left_q;
    logic        buzzer_q;
    logic [25:0] data_q;

    // Bit mask of the duration fields enabled by {wash, rinse, spin}.
    function automatic logic [25:0] prog_mask(input logic [2:0] m);
        logic [25:0] msk;
        msk = '0;
        if (m[2]) msk[25:16] = '1;
        if (m[1]) msk[15:6]  = '1;
        if (m[0]) msk[5:0]   = '1;
        return msk;
    endfunction

    // Mode selection steps downward and skips the empty program 0.
    function automatic logic [2:0] mode_step(input logic [2:0] m);
        return (m <= 3'd1) ? 3'd7 : m - 3'd1;
    endfunction

    // Program state machine: power button overrides everything but reset,
    // and a transition taken in a cycle swallows a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SHUTDOWN;
            err_ret_q  <= S_SET;
            mode_q     <= 3'b111;
            sec_left_q <= 3'd0;
            buzzer_q   <= 1'b0;
        end else if (power_btn) begin
            if (state_q == S_SHUTDOWN) begin
                state_q    <= S_BEGIN;
                sec_left_q <= INIT_SEC;
            end else begin
                state_q    <= S_SHUTDOWN;
                sec_left_q <= 3'd0;
                buzzer_q   <= 1'b0;
            end
        end else begin
            case (state_q)
                S_SHUTDOWN: begin
                    sec_left_q <= 3'd0;
                    buzzer_q   <= 1'b0;
                end

                S_BEGIN: begin
                    if (tick) begin
                        if (sec_left_q <= 3'd1) begin
                            state_q    <= S_SET;
                            sec_left_q <= 3'd0;
                        end else begin
                            sec_left_q <= sec_left_q - 3'd1;
                        end
                    end
                end

                S_SET: begin
                    if (start_btn) begin
                        if (door_open) begin
                            state_q   <= S_ERROR;
                            err_ret_q <= S_SET;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else if (mode_btn) begin
                        mode_q <= mode_step(mode_q);
                    end
                end

                S_RUN: begin
                    if (run_done) begin
                        state_q    <= S_FINISH;
                        sec_left_q <= FINISH_SEC;
                        buzzer_q   <= FINISH_SEC[0];
                    end else if (door_open) begin
                        state_q   <= S_ERROR;
                        err_ret_q <= S_PAUSE;
                    end else if (start_btn) begin
                        state_q <= S_PAUSE;
                    end
                end

                S_PAUSE: begin
                    if (start_btn) begin
                        if (door_open) begin
                            state_q   <= S_ERROR;
                            err_ret_q <= S_PAUSE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end

                S_ERROR: begin
                    if (start_btn && !door_open) begin
                        state_q  <= err_ret_q;
                        buzzer_q <= 1'b0;
                    end else if (tick) begin
                        buzzer_q <= ~buzzer_q;
                    end
                end

                S_FINISH: begin
                    if (tick) begin
                        if (sec_left_q <= 3'd1) begin
                            state_q    <= S_SHUTDOWN;
                            sec_left_q <= 3'd0;
                            buzzer_q   <= 1'b0;
                        end else begin
                            sec_left_q <= sec_left_q - 3'd1;
                            // Buzzer follows the parity of the new count.
                            buzzer_q   <= ~sec_left_q[0];
                        end
                    end
                end

                default: begin
                    state_q    <= S_SHUTDOWN;
                    sec_left_q <= 3'd0;
                    buzzer_q   <= 1'b0;
                end
            endcase
        end
    end

    // Stage-duration word: tracks mode while selecting, frozen while a
    // program is in progress, and cleared whenever no program is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            case (state_q)
                S_SET:                   data_q <= BASE_PROG & prog_mask(mode_q);
                S_RUN, S_PAUSE, S_ERROR: data_q <= data_q;
                default:                 data_q <= '0;
            endcase
        end
    end

    assign state    = state_q;
    assign data     = data_q;
    assign mode     = mode_q;
    assign sec_left = sec_left_q;
    assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: one linear walk through power-up,
// mode selection, run/pause, door alarm, finish alarm, power-off and reset.
module tb_wash_sequencer;

    logic        clk = 1'b0;
    logic        rst, tick, power_btn, start_btn, mode_btn, door_open, run_done;
    logic [2:0]  state, mode, sec_left;
    logic [25:0] data;
    logic        buzzer;

    int n_cmp = 0;
    int n_bad = 0;

    wash_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .power_btn (power_btn),
        .start_btn (start_btn),
        .mode_btn  (mode_btn),
        .door_open (door_open),
        .run_done  (run_done),
        .state     (state),
        .data      (data),
        .mode      (mode),
        .sec_left  (sec_left),
        .buzzer    (buzzer)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [2:0]  mode_exp [4];
    logic [25:0] data_exp [4];

    initial begin
        mode_exp = '{3'd6, 3'd5, 3'd4, 3'd3};
        data_exp = '{26'h1AB4900, 26'h1AB000B, 26'h1AB0000, 26'h000490B};

        rst = 1; tick = 0; power_btn = 0; start_btn = 0; mode_btn = 0;
        door_open = 0; run_done = 0;
        step(); step();
        rst = 0;
        check("rst_state",  32'(state), 0);
        check("rst_mode",   32'(mode), 7);
        check("rst_data",   32'(data), 0);
        check("rst_sec",    32'(sec_left), 0);
        check("rst_buzzer", 32'(buzzer), 0);

        // Power up; buttons other than power are ignored in BEGIN.
        power_btn = 1; step(); power_btn = 0;
        check("begin_state", 32'(state), 1);
        check("begin_sec",   32'(sec_left), 5);
        start_btn = 1; mode_btn = 1; step(); start_btn = 0; mode_btn = 0;
        check("begin_ign_state", 32'(state), 1);
        check("begin_ign_mode",  32'(mode), 7);
        for (int i = 0; i < 5; i++) begin
            tick = 1; step(); tick = 0;
            check("begin_tick_sec",   32'(sec_left), (i < 4) ? 32'(4 - i) : 0);
            check("begin_tick_state", 32'(state), (i < 4) ? 1 : 2);
        end
        check("set_entry_data", 32'(data), 0);
        step();
        check("set_full_data", 32'(data), 32'h1AB490B);

        // Mode stepping with one-cycle data latency.
        for (int i = 0; i < 4; i++) begin
            mode_btn = 1; step(); mode_btn = 0;
            check("mode_step", 32'(mode), 32'(mode_exp[i]));
            step();
            check("mode_data", 32'(data), 32'(data_exp[i]));
        end

        // start and mode together: start wins.
        start_btn = 1; mode_btn = 1; step(); start_btn = 0; mode_btn = 0;
        check("run_state", 32'(state), 3);
        check("run_mode",  32'(mode), 3);
        mode_btn = 1; step(); mode_btn = 0;
        check("run_mode_ign", 32'(mode), 3);
        check("run_data",     32'(data), 32'h000490B);
        start_btn = 1; step(); start_btn = 0;
        check("pause_state", 32'(state), 5);
        check("pause_data",  32'(data), 32'h000490B);
        start_btn = 1; step(); start_btn = 0;
        check("resume_state", 32'(state), 3);
        check("resume_data",  32'(data), 32'h000490B);

        // Door opened mid-run: alarm toggles on ticks.
        door_open = 1; step();
        check("err_state",  32'(state), 4);
        check("err_buzz0",  32'(buzzer), 0);
        tick = 1; step(); tick = 0;
        check("err_buzz1",  32'(buzzer), 1);
        tick = 1; step(); tick = 0;
        check("err_buzz2",  32'(buzzer), 0);
        tick = 1; step(); tick = 0;
        check("err_buzz3",  32'(buzzer), 1);
        start_btn = 1; step(); start_btn = 0;
        check("err_open_start", 32'(state), 4);
        check("err_open_buzz",  32'(buzzer), 1);
        door_open = 0; step();
        check("err_closed_wait", 32'(state), 4);
        start_btn = 1; step(); start_btn = 0;
        check("err_ret_pause", 32'(state), 5);
        check("err_clr_buzz",  32'(buzzer), 0);
        check("err_data",      32'(data), 32'h000490B);

        // Back to run, then run_done beats door_open.
        start_btn = 1; step(); start_btn = 0;
        check("rerun_state", 32'(state), 3);
        run_done = 1; door_open = 1; step(); run_done = 0; door_open = 0;
        check("fin_state", 32'(state), 6);
        check("fin_sec",   32'(sec_left), 5);
        check("fin_buzz",  32'(buzzer), 1);
        step();
        check("fin_data", 32'(data), 0);
        for (int i = 0; i < 4; i++) begin
            tick = 1; step(); tick = 0;
            check("fin_tick_sec",  32'(sec_left), 32'(4 - i));
            check("fin_tick_buzz", 32'(buzzer), (i % 2 == 0) ? 0 : 1);
            check("fin_tick_state", 32'(state), 6);
        end
        tick = 1; step(); tick = 0;
        check("fin_end_state", 32'(state), 0);
        check("fin_end_buzz",  32'(buzzer), 0);
        check("fin_end_data",  32'(data), 0);

        // Power with a coincident tick: tick not applied to BEGIN.
        power_btn = 1; tick = 1; step(); power_btn = 0; tick = 0;
        check("pwr_tick_state", 32'(state), 1);
        check("pwr_tick_sec",   32'(sec_left), 5);
        for (int i = 0; i < 5; i++) begin
            tick = 1; step(); tick = 0;
        end
        check("set2_state", 32'(state), 2);
        step();
        check("set2_data", 32'(data), 32'h000490B);
        start_btn = 1; step(); start_btn = 0;
        check("run2_state", 32'(state), 3);
        power_btn = 1; step(); power_btn = 0;
        check("pwr_off_state", 32'(state), 0);
        check("pwr_off_mode",  32'(mode), 3);
        step();
        check("pwr_off_data", 32'(data), 0);

        // Start in SET with door open returns to SET once cleared.
        power_btn = 1; step(); power_btn = 0;
        for (int i = 0; i < 5; i++) begin
            tick = 1; step(); tick = 0;
        end
        door_open = 1; start_btn = 1; step(); start_btn = 0;
        check("set_err_state", 32'(state), 4);
        door_open = 0; start_btn = 1; step(); start_btn = 0;
        check("set_err_ret", 32'(state), 2);

        // PAUSE with door open goes to ERROR, returning to PAUSE.
        start_btn = 1; step(); start_btn = 0;
        start_btn = 1; step(); start_btn = 0;
        check("pause2_state", 32'(state), 5);
        door_open = 1; start_btn = 1; step(); start_btn = 0;
        check("pause_err_state", 32'(state), 4);
        door_open = 0; start_btn = 1; step(); start_btn = 0;
        check("pause_err_ret", 32'(state), 5);

        // Reset mid-pause.
        rst = 1; step(); rst = 0;
        check("rst2_state", 32'(state), 0);
        check("rst2_mode",  32'(mode), 7);
        check("rst2_data",  32'(data), 0);
        check("rst2_sec",   32'(sec_left), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
